// File: rtl/aes_ahb_master.sv
// AHB-lite master that feeds key and plaintext to a memory-mapped AES engine
// and reads the 128-bit ciphertext back, one non-pipelined 32-bit transfer at a time.
module aes_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] KEY_OFF   = 32'h0000_0000,
    parameter logic [31:0] DATA_OFF  = 32'h0000_0010,
    parameter logic [31:0] RES_OFF   = 32'h0000_0020
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] ciphertext,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic         HRESP
);

    typedef enum logic [2:0] {
        IDLE, WADDR, WDATA, RADDR, RDATA, DONE, ERR
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     wcnt_q, wcnt_d, wnext;
    logic [1:0]     rcnt_q, rcnt_d, rnext;
    logic [127:0]   key_q, key_d, pt_q, pt_d;
    logic [127:0]   rbuf_q, rbuf_d, ct_q, ct_d;
    logic [31:0]    haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic           hwrite_q, hwrite_d;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
        case (idx)
            2'd0:    return blk[127:96];
            2'd1:    return blk[95:64];
            2'd2:    return blk[63:32];
            default: return blk[31:0];
        endcase
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] off, input logic [1:0] idx);
        return BASE_ADDR + off + {28'd0, idx, 2'b00};
    endfunction

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        key_d    = key_q;
        pt_d     = pt_q;
        rbuf_d   = rbuf_q;
        ct_d     = ct_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        wnext    = wcnt_q + 3'd1;
        rnext    = rcnt_q + 2'd1;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        HTRANS   = 2'b00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // First address/data come straight from the inputs; later words from the captured copy.
                    busy     = 1'b1;
                    state_d  = WADDR;
                    key_d    = key;
                    pt_d     = plaintext;
                    wcnt_d   = '0;
                    rcnt_d   = '0;
                    haddr_d  = word_addr(KEY_OFF, 2'd0);
                    hwrite_d = 1'b1;
                    hwdata_d = key[127:96];
                end
            end
            WADDR: begin
                busy    = 1'b1;
                HTRANS  = 2'b10;
                state_d = WDATA;
            end
            WDATA: begin
                busy = 1'b1;
                if (HRESP) begin
                    state_d = ERR;
                end else if (HREADY) begin
                    if (wcnt_q == 3'd7) begin
                        state_d  = RADDR;
                        haddr_d  = word_addr(RES_OFF, 2'd0);
                        hwrite_d = 1'b0;
                    end else begin
                        state_d  = WADDR;
                        wcnt_d   = wnext;
                        haddr_d  = word_addr(wnext[2] ? DATA_OFF : KEY_OFF, wnext[1:0]);
                        hwdata_d = word_of(wnext[2] ? pt_q : key_q, wnext[1:0]);
                    end
                end
            end
            RADDR: begin
                busy    = 1'b1;
                HTRANS  = 2'b10;
                state_d = RDATA;
            end
            RDATA: begin
                busy = 1'b1;
                if (HRESP) begin
                    state_d = ERR;
                end else if (HREADY) begin
                    case (rcnt_q)
                        2'd0:    rbuf_d[127:96] = HRDATA;
                        2'd1:    rbuf_d[95:64]  = HRDATA;
                        2'd2:    rbuf_d[63:32]  = HRDATA;
                        default: rbuf_d[31:0]   = HRDATA;
                    endcase
                    if (rcnt_q == 2'd3) begin
                        // Result is committed only when complete, so an aborted read leaves it intact.
                        state_d = DONE;
                        ct_d    = rbuf_d;
                    end else begin
                        state_d = RADDR;
                        rcnt_d  = rnext;
                        haddr_d = word_addr(RES_OFF, rnext);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                error   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            key_q    <= '0;
            pt_q     <= '0;
            rbuf_q   <= '0;
            ct_q     <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            key_q    <= key_d;
            pt_q     <= pt_d;
            rbuf_q   <= rbuf_d;
            ct_q     <= ct_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end

    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HWDATA     = hwdata_q;
    assign HSIZE      = 3'b010;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Bench for aes_ahb_master: an AHB slave model with programmable waits/errors
// records every transfer; expected traffic and timing come from the transfer rules.
module tb_aes_ahb_master;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] KOFF = 32'h00;
    localparam logic [31:0] DOFF = 32'h10;
    localparam logic [31:0] ROFF = 32'h20;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;
    logic         busy, done, error;
    logic [127:0] ciphertext;
    logic [31:0]  HADDR, HWDATA;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [31:0]  HRDATA = '0;
    logic         HREADY = 1'b1;
    logic         HRESP = 1'b0;

    aes_ahb_master #(
        .BASE_ADDR(BASE),
        .KEY_OFF  (KOFF),
        .DATA_OFF (DOFF),
        .RES_OFF  (ROFF)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .key(key), .plaintext(plaintext),
        .busy(busy), .done(done), .error(error), .ciphertext(ciphertext),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           passed = 0, total = 0, nfail = 0;
    int           wait_cfg [16];
    logic [31:0]  rd_word [16];
    int           err_idx = -1;
    logic [127:0] exp_ct = '0;

    logic [31:0]  m_addr [16];
    logic [31:0]  m_wdata [16];
    logic         m_wr [16];
    int           m_acyc [16];
    int           nxfer = 0, cur = 0, wleft = 0;
    bit           pending = 0, busy_prev = 0;
    int           done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1;
    int           first_busy = -1, last_busy = -1;

    // Slave + monitor: decides HREADY/HRESP/HRDATA for the current cycle mid-cycle.
    always @(negedge clk) begin
        if (busy) begin
            if (!busy_prev) first_busy = cyc;
            last_busy = cyc;
        end
        busy_prev = busy;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (!n_rst) begin
            pending = 0; HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            HRDATA = $urandom; HREADY = 1'b1; HRESP = 1'b0;
            if (pending) begin
                if (wleft > 0) begin
                    HREADY = 1'b0; wleft--;
                end else begin
                    pending = 0;
                    if (m_wr[cur]) m_wdata[cur] = HWDATA;
                    else HRDATA = rd_word[cur];
                    if (cur == err_idx) HRESP = 1'b1;
                end
            end
            if (HTRANS == 2'b10 && nxfer < 16) begin
                m_addr[nxfer] = HADDR; m_wr[nxfer] = HWRITE; m_acyc[nxfer] = cyc;
                cur = nxfer; wleft = wait_cfg[nxfer]; pending = 1; nxfer++;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_htrans"}, HTRANS, 2'b00);
        chk({pfx, "_haddr"}, HADDR, 0);
        chk({pfx, "_hwrite"}, HWRITE, 0);
        chk({pfx, "_hwdata"}, HWDATA, 0);
        chk({pfx, "_hsize"}, HSIZE, 3'b010);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_error"}, error, 0);
        chk({pfx, "_ct"}, ciphertext, 0);
    endtask

    // One full request; expected bus traffic derived from word order, offsets and wait counts.
    task automatic run(input string nm, input logic [127:0] k, input logic [127:0] p,
                       input int err_at, input bit bump);
        int T, d0, e0, ntr, acc;
        bit seen;
        logic [127:0] src;
        logic [31:0] want_addr, snap_a, snap_d;
        logic snap_w;
        err_idx = err_at;
        @(posedge clk); #1;
        key = k; plaintext = p; start = 1'b1; n_rst = 1'b1;
        first_busy = -1; last_busy = -1; nxfer = 0;
        d0 = done_cnt; e0 = err_cnt; T = cyc;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge clk); #1;
            start = bump && (cyc == T + 5);
            if (cyc == T + 1 || (bump && cyc == T + 5)) begin
                key = {$urandom, $urandom, $urandom, $urandom};
                plaintext = {$urandom, $urandom, $urandom, $urandom};
            end
            seen = (done_cnt != d0) || (err_cnt != e0);
        end
        start = 1'b0;
        chk({nm, "_timeout"}, seen, 1);
        repeat (4) @(posedge clk);
        #1;
        ntr = (err_at >= 0) ? err_at + 1 : 12;
        chk({nm, "_nxfer"}, nxfer, ntr);
        acc = T + 1;
        for (int j = 0; j < ntr && j < nxfer; j++) begin
            if (j < 4)      want_addr = BASE + KOFF + 4 * j;
            else if (j < 8) want_addr = BASE + DOFF + 4 * (j - 4);
            else            want_addr = BASE + ROFF + 4 * (j - 8);
            chk($sformatf("%s_addr%0d", nm, j), m_addr[j], want_addr);
            chk($sformatf("%s_wr%0d", nm, j), m_wr[j], (j < 8) ? 1 : 0);
            if (j < 8) begin
                src = (j < 4) ? k : p;
                chk($sformatf("%s_wdata%0d", nm, j), m_wdata[j], src[32 * (3 - (j % 4)) +: 32]);
            end
            chk($sformatf("%s_acyc%0d", nm, j), m_acyc[j], acc);
            acc = acc + 2 + wait_cfg[j];
        end
        if (err_at >= 0) begin
            chk({nm, "_errcnt"}, err_cnt, e0 + 1);
            chk({nm, "_donecnt"}, done_cnt, d0);
            chk({nm, "_errcyc"}, err_cyc, acc);
        end else begin
            exp_ct = {rd_word[8], rd_word[9], rd_word[10], rd_word[11]};
            chk({nm, "_donecnt"}, done_cnt, d0 + 1);
            chk({nm, "_errcnt"}, err_cnt, e0);
            chk({nm, "_donecyc"}, done_cyc, acc);
        end
        chk({nm, "_busy_first"}, first_busy, T);
        chk({nm, "_busy_last"}, last_busy, acc - 1);
        chk({nm, "_ct"}, ciphertext, exp_ct);
        snap_a = HADDR; snap_w = HWRITE; snap_d = HWDATA;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_idle_htrans"}, HTRANS, 2'b00);
        chk({nm, "_idle_stable"}, {HADDR, HWRITE, HWDATA}, {snap_a, snap_w, snap_d});
    endtask

    localparam logic [127:0] K0 = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    localparam logic [127:0] P0 = 128'h3243F6A8_885A308D_313198A2_E0370734;

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) begin wait_cfg[i] = 0; rd_word[i] = '0; end

        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // Reference vector, zero waits; start coincides with reset release.
        rd_word[8] = 32'h3925841D; rd_word[9] = 32'h02DC09FB;
        rd_word[10] = 32'hDC118597; rd_word[11] = 32'h196A0B32;
        run("vec", K0, P0, -1, 0);

        // Ten wait states on the first result read.
        rd_word[9] = 32'h11112222; rd_word[10] = 32'h33334444; rd_word[11] = 32'h55556666;
        wait_cfg[8] = 10;
        run("wait", K0, P0, -1, 0);
        chk("wait_ct_w0", ciphertext[127:96], 32'h3925841D);
        wait_cfg[8] = 0;

        // Error response on the fifth write.
        run("err5", {$urandom, $urandom, $urandom, $urandom}, P0, 4, 0);

        // Second start mid-transfer with new inputs.
        rd_word[8] = $urandom;
        run("bump", {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, -1, 1);

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 12; j++) wait_cfg[j] = $urandom_range(0, 3);
            for (int j = 8; j < 12; j++) rd_word[j] = $urandom;
            run($sformatf("rnd%0d", r), {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                (r == 2) ? int'($urandom_range(0, 11)) : -1, 0);
        end

        // Reset during the third read's data phase.
        for (int j = 0; j < 16; j++) wait_cfg[j] = 0;
        wait_cfg[10] = 5;
        err_idx = -1;
        @(posedge clk); #1;
        key = K0; plaintext = P0; start = 1'b1; nxfer = 0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (nxfer >= 11) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("midrst_reach", seen, 1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        chk_reset_outputs("midrst");
        exp_ct = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_resume", nxfer, 11);
        chk("midrst_busy", busy, 0);
        wait_cfg[10] = 0;
        for (int j = 8; j < 12; j++) rd_word[j] = $urandom;
        run("after_rst", {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, -1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
